sync_mem_mp: RTL and testbench
==============================

Name: sync_mem_mp

Overview:
- Byte-addressed, multi-port synchronous memory; parametrised successor of the team's fixed 2-write/3-read simulation memory.
- Serves the core's instruction fetch, data path and host/debug ports from one array.
- Adds:
  - a configurable number of read ports
  - configurable read latency with per-port valid strobes
  - optional write-to-read forwarding
  - defined write-write priority
  - a collision counter

Parameters:
- NUM_BYTES, 2097152, array size in bytes; power of two.
- DATA_WIDTH, 64, access width in bits; multiple of 8.
- NUM_RPORTS, 3, number of read ports, 1..8.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- WR_FWD, 1, 1 = same-edge write bytes forwarded to reads; 0 = reads return pre-write data.
- Derived: AW = clog2(NUM_BYTES), MW = DATA_WIDTH/8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- w_en  in  2  write enable per write port; port 0 = host, port 1 = data path.
- w_addr  in  2*AW  byte address per write port, port p at [p*AW +: AW].
- w_data  in  2*DATA_WIDTH  write data per port.
- w_mask  in  2*MW  byte mask per port; bit i covers byte i.
- r_en  in  NUM_RPORTS  read request per port.
- r_addr  in  NUM_RPORTS*AW  byte address per read port.
- r_data  out  NUM_RPORTS*DATA_WIDTH  read data per port.
- r_valid  out  NUM_RPORTS  one-cycle strobe, r_data valid.
- wcoll_cnt  out  16  saturating count of write-write byte collisions.

Behaviour:
- Reset values:
  - r_valid = 0, r_data = 0, wcoll_cnt = 0; all pipeline registers cleared.
  - Memory array is not cleared.
- While reset is high: writes ignored, requests ignored.
- Addressing:
  - Byte i of an access at address A targets mem[(A+i) mod NUM_BYTES]; unaligned accesses are legal.
  - Wrap-around at the top of the array is required.
- Writes:
  - Byte i of port p is written at the rising edge when w_en[p] and w_mask[p*MW+i] are both set.
  - Both ports may write in the same cycle.
  - If both ports target the same physical byte, port 1 wins.
  - Each colliding byte increments wcoll_cnt by 1 in that cycle (sum over bytes), saturating at 0xFFFF.
- Reads:
  - A request sampled at edge T (r_en[k] = 1) reads the array state before edge T's writes.
  - WR_FWD = 1: each byte also written at edge T is replaced by the winning write byte (port 1 over port 0).
  - WR_FWD = 0: no replacement; returns old data.
  - Writes at edges after T never affect that request's data.
- Latency:
  - RD_LATENCY = 1: r_data[k] and r_valid[k] update at edge T; visible during cycle T+1.
  - RD_LATENCY = 2: one extra pipeline register; valid during cycle T+2.
- Throughput and hold:
  - Fully pipelined, one request per port per cycle, no stalls, no ready signal.
  - r_valid[k] is high exactly one cycle per request.
  - r_data[k] holds its last value when no new result arrives.
- Ports are independent: identical addresses on several read ports return identical data.
- Reset mid-operation: in-flight reads are discarded and produce no r_valid after reset deasserts. The first request accepted is the one sampled at the first edge with reset low.
- RD_LATENCY values other than 1 or 2 are an elaboration error.

Test Plan:
- Reset then write 0x1122334455667788, mask 0xFF, to addr 0x100 via port 0; read addr 0x100 on port 2 next cycle → r_data = 0x1122334455667788, r_valid high 1 cycle after request (RD_LATENCY=1); repeat with RD_LATENCY=2 → valid 2 cycles after.
- Unaligned/wrap: write 0xAABBCCDDEEFF0011 at addr NUM_BYTES-3 → bytes 0x11,0x00,0xFF at top, rest at 0..4; read same addr returns the same word.
- Collision: same edge, port 0 writes 0x0101..01 and port 1 writes 0x0202..02, both addr 0x200, masks 0xFF and 0x0F → read = 0x0101010102020202; wcoll_cnt = 4.
- Forwarding: mem[0x300] = 0, same edge write 0xFFFF..FF mask 0x03 and read 0x300 → WR_FWD=1 gives 0x000000000000FFFF; WR_FWD=0 gives 0.
- Reset mid-flight (RD_LATENCY=2): issue read, assert reset next cycle → no r_valid, r_data = 0; after release, new read completes normally.
- Saturation: force 70000 collision bytes → wcoll_cnt stays 0xFFFF.

Source files
------------

// File: rtl/sync_mem_mp_if.sv
// rtl/sync_mem_mp_if.sv - port bundle for the multi-port synchronous memory
interface sync_mem_mp_if #(
    parameter int AW         = 21,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RPORTS = 3
);
    localparam int MW = DATA_WIDTH / 8;

    logic [1:0]                       w_en;
    logic [2*AW-1:0]                  w_addr;
    logic [2*DATA_WIDTH-1:0]          w_data;
    logic [2*MW-1:0]                  w_mask;
    logic [NUM_RPORTS-1:0]            r_en;
    logic [NUM_RPORTS*AW-1:0]         r_addr;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] r_data;
    logic [NUM_RPORTS-1:0]            r_valid;
    logic [15:0]                      wcoll_cnt;

    modport master (
        output w_en, w_addr, w_data, w_mask, r_en, r_addr,
        input  r_data, r_valid, wcoll_cnt
    );

    modport slave (
        input  w_en, w_addr, w_data, w_mask, r_en, r_addr,
        output r_data, r_valid, wcoll_cnt
    );
endinterface

// File: rtl/sync_mem_mp.sv
// rtl/sync_mem_mp.sv - byte-addressed multi-port synchronous memory, 2 write / N read ports
module sync_mem_mp #(
    parameter int NUM_BYTES  = 2097152,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_RPORTS = 3,
    parameter int RD_LATENCY = 1,
    parameter int WR_FWD     = 1
) (
    input  logic         clk,
    input  logic         reset,
    sync_mem_mp_if.slave bus
);
    localparam int AW = $clog2(NUM_BYTES);
    localparam int MW = DATA_WIDTH / 8;
    localparam int RW = NUM_RPORTS * DATA_WIDTH;

    logic [7:0] mem [NUM_BYTES];

    // Per-byte physical addresses; AW-bit addition gives the wrap at the top of the array.
    logic [AW-1:0] wb_addr [2][MW];
    logic          wb_en   [2][MW];
    logic [7:0]    wb_data [2][MW];
    logic [AW-1:0] rb_addr [NUM_RPORTS][MW];

    // Expand each port's base address into byte addresses and byte enables.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < MW; i++) begin
                wb_addr[p][i] = bus.w_addr[p*AW +: AW] + AW'(i);
                wb_en[p][i]   = bus.w_en[p] & bus.w_mask[p*MW + i];
                wb_data[p][i] = bus.w_data[p*DATA_WIDTH + 8*i +: 8];
            end
        end
        for (int k = 0; k < NUM_RPORTS; k++) begin
            for (int i = 0; i < MW; i++) begin
                rb_addr[k][i] = bus.r_addr[k*AW +: AW] + AW'(i);
            end
        end
    end

    // A port-0 byte collides when some enabled port-1 byte lands on the same physical byte.
    logic [MW-1:0] coll_vec;
    always_comb begin
        coll_vec = '0;
        for (int i = 0; i < MW; i++) begin
            for (int j = 0; j < MW; j++) begin
                if (wb_en[0][i] && wb_en[1][j] && (wb_addr[0][i] == wb_addr[1][j])) begin
                    coll_vec[i] = 1'b1;
                end
            end
        end
    end

    logic [15:0] coll_cnt_q;
    logic [16:0] coll_sum;
    assign coll_sum = {1'b0, coll_cnt_q} + 17'($countones(coll_vec));

    // Saturating collision counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll_cnt_q <= '0;
        end else begin
            coll_cnt_q <= coll_sum[16] ? 16'hFFFF : coll_sum[15:0];
        end
    end

    assign bus.wcoll_cnt = coll_cnt_q;

    // Array write; port 1 is applied last so it wins on a shared byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < MW; i++) begin
                    if (wb_en[p][i]) begin
                        mem[wb_addr[p][i]] <= wb_data[p][i];
                    end
                end
            end
        end
    end

    // Read word: pre-write array contents, optionally overlaid with this edge's winning write bytes.
    logic [RW-1:0] rd_word;
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_RPORTS; k++) begin
            for (int i = 0; i < MW; i++) begin
                rd_word[(k*MW + i)*8 +: 8] = mem[rb_addr[k][i]];
                if (WR_FWD != 0) begin
                    for (int p = 0; p < 2; p++) begin
                        for (int j = 0; j < MW; j++) begin
                            if (wb_en[p][j] && (wb_addr[p][j] == rb_addr[k][i])) begin
                                rd_word[(k*MW + i)*8 +: 8] = wb_data[p][j];
                            end
                        end
                    end
                end
            end
        end
    end

    logic [RW-1:0]         s1_data;
    logic [NUM_RPORTS-1:0] s1_valid;

    // First read stage; data only moves on a request so idle ports hold their last result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data  <= '0;
            s1_valid <= '0;
        end else begin
            s1_valid <= bus.r_en;
            for (int k = 0; k < NUM_RPORTS; k++) begin
                if (bus.r_en[k]) begin
                    s1_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_word[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign bus.r_data  = s1_data;
            assign bus.r_valid = s1_valid;
        end else if (RD_LATENCY == 2) begin : g_lat2
            logic [RW-1:0]         s2_data;
            logic [NUM_RPORTS-1:0] s2_valid;

            // Second read stage, advancing each port only when stage one holds a fresh result.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_data  <= '0;
                    s2_valid <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    for (int k = 0; k < NUM_RPORTS; k++) begin
                        if (s1_valid[k]) begin
                            s2_data[k*DATA_WIDTH +: DATA_WIDTH] <= s1_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end

            assign bus.r_data  = s2_data;
            assign bus.r_valid = s2_valid;
        end else begin : g_bad_latency
            $error("sync_mem_mp: RD_LATENCY must be 1 or 2");
        end
    endgenerate
endmodule

// File: tb/tb_sync_mem_mp.sv
// tb/tb_sync_mem_mp.sv - directed self-checking bench for sync_mem_mp
module tb_sync_mem_mp;
    localparam int NB  = 4096;
    localparam int AW  = 12;
    localparam int DW  = 64;
    localparam int NRP = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errs   = 0;

    always #5 clk = ~clk;

    sync_mem_mp_if #(.AW(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NRP)) ifa ();
    sync_mem_mp_if #(.AW(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NRP)) ifb ();

    assign ifb.w_en   = ifa.w_en;
    assign ifb.w_addr = ifa.w_addr;
    assign ifb.w_data = ifa.w_data;
    assign ifb.w_mask = ifa.w_mask;
    assign ifb.r_en   = ifa.r_en;
    assign ifb.r_addr = ifa.r_addr;

    sync_mem_mp #(.NUM_BYTES(NB), .DATA_WIDTH(DW), .NUM_RPORTS(NRP), .RD_LATENCY(1), .WR_FWD(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    sync_mem_mp #(.NUM_BYTES(NB), .DATA_WIDTH(DW), .NUM_RPORTS(NRP), .RD_LATENCY(2), .WR_FWD(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.w_en   = '0;
        ifa.w_addr = '0;
        ifa.w_data = '0;
        ifa.w_mask = '0;
        ifa.r_en   = '0;
        ifa.r_addr = '0;
    endtask

    task automatic set_write(input int p, input logic [AW-1:0] addr, input logic [63:0] data,
                             input logic [7:0] mask);
        ifa.w_en[p]              = 1'b1;
        ifa.w_addr[p*AW +: AW]   = addr;
        ifa.w_data[p*DW +: DW]   = data;
        ifa.w_mask[p*8 +: 8]     = mask;
    endtask

    // Issue one read (plus any writes already set up) and follow it through both latencies.
    task automatic read_check(input string tag, input logic [NRP-1:0] ports, input logic [AW-1:0] addr,
                              input logic [63:0] exp_a, input logic [63:0] exp_b);
        for (int k = 0; k < NRP; k++) begin
            if (ports[k]) begin
                ifa.r_en[k]            = 1'b1;
                ifa.r_addr[k*AW +: AW] = addr;
            end
        end
        tick();
        clear_inputs();
        for (int k = 0; k < NRP; k++) begin
            if (ports[k]) begin
                check($sformatf("%s p%0d lat1 valid", tag, k), 64'(ifa.r_valid[k]), 64'd1);
                check($sformatf("%s p%0d lat1 data", tag, k), ifa.r_data[k*DW +: DW], exp_a);
                check($sformatf("%s p%0d lat2 early", tag, k), 64'(ifb.r_valid[k]), 64'd0);
            end
        end
        tick();
        for (int k = 0; k < NRP; k++) begin
            if (ports[k]) begin
                check($sformatf("%s p%0d lat1 drop", tag, k), 64'(ifa.r_valid[k]), 64'd0);
                check($sformatf("%s p%0d lat1 hold", tag, k), ifa.r_data[k*DW +: DW], exp_a);
                check($sformatf("%s p%0d lat2 valid", tag, k), 64'(ifb.r_valid[k]), 64'd1);
                check($sformatf("%s p%0d lat2 data", tag, k), ifb.r_data[k*DW +: DW], exp_b);
            end
        end
        tick();
        for (int k = 0; k < NRP; k++) begin
            if (ports[k]) begin
                check($sformatf("%s p%0d lat2 drop", tag, k), 64'(ifb.r_valid[k]), 64'd0);
                check($sformatf("%s p%0d lat2 hold", tag, k), ifb.r_data[k*DW +: DW], exp_b);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();

        check("rst a valid", 64'(ifa.r_valid), 64'd0);
        check("rst b valid", 64'(ifb.r_valid), 64'd0);
        for (int k = 0; k < NRP; k++) begin
            check($sformatf("rst a data p%0d", k), ifa.r_data[k*DW +: DW], 64'd0);
            check($sformatf("rst b data p%0d", k), ifb.r_data[k*DW +: DW], 64'd0);
        end
        check("rst a wcoll", 64'(ifa.wcoll_cnt), 64'd0);
        check("rst b wcoll", 64'(ifb.wcoll_cnt), 64'd0);
        reset = 1'b0;

        // Basic write then read on port 2.
        set_write(0, 12'h100, 64'h1122334455667788, 8'hFF);
        tick();
        clear_inputs();
        read_check("basic", 3'b100, 12'h100, 64'h1122334455667788, 64'h1122334455667788);

        // Unaligned access wrapping over the top of the array, read on two ports at once.
        set_write(0, 12'(NB - 3), 64'hAABBCCDDEEFF0011, 8'hFF);
        tick();
        clear_inputs();
        read_check("wrap", 3'b011, 12'(NB - 3), 64'hAABBCCDDEEFF0011, 64'hAABBCCDDEEFF0011);

        // Single-byte port-1 write to address 0 lands in the wrapped part of that word.
        set_write(1, 12'h000, 64'h0000000000000077, 8'h01);
        tick();
        clear_inputs();
        read_check("wrap patch", 3'b001, 12'(NB - 3), 64'hAABBCCDD77FF0011, 64'hAABBCCDD77FF0011);

        // Same-address collision: port 1 owns the low four bytes.
        set_write(0, 12'h200, 64'h0101010101010101, 8'hFF);
        set_write(1, 12'h200, 64'h0202020202020202, 8'h0F);
        tick();
        clear_inputs();
        check("coll a cnt", 64'(ifa.wcoll_cnt), 64'd4);
        check("coll b cnt", 64'(ifb.wcoll_cnt), 64'd4);
        read_check("coll", 3'b010, 12'h200, 64'h0101010102020202, 64'h0101010102020202);

        // Offset collision: overlap covers bytes 0x214..0x217.
        set_write(0, 12'h210, 64'h0101010101010101, 8'hFF);
        set_write(1, 12'h214, 64'h0303030303030303, 8'hFF);
        tick();
        clear_inputs();
        check("coll2 a cnt", 64'(ifa.wcoll_cnt), 64'd8);
        read_check("coll2", 3'b001, 12'h210, 64'h0303030301010101, 64'h0303030301010101);

        // Forwarding: same-edge write bytes appear only in the WR_FWD=1 instance.
        set_write(0, 12'h300, 64'h0, 8'hFF);
        set_write(1, 12'h308, 64'h0, 8'hFF);
        tick();
        clear_inputs();
        set_write(0, 12'h300, 64'hFFFFFFFFFFFFFFFF, 8'h03);
        read_check("fwd", 3'b001, 12'h300, 64'h000000000000FFFF, 64'h0);
        read_check("fwd after", 3'b001, 12'h300, 64'h000000000000FFFF, 64'h000000000000FFFF);

        // Forwarding with a same-edge collision: port 1 byte wins in the forwarded data.
        set_write(0, 12'h308, 64'h1111111111111111, 8'h03);
        set_write(1, 12'h308, 64'h2222222222222222, 8'h02);
        read_check("fwd coll", 3'b100, 12'h308, 64'h0000000000002211, 64'h0);
        check("fwd coll cnt", 64'(ifb.wcoll_cnt), 64'd9);

        // Reset while a latency-2 read is in flight.
        ifa.r_en[0]          = 1'b1;
        ifa.r_addr[0 +: AW]  = 12'h100;
        tick();
        clear_inputs();
        reset = 1'b1;
        #1;
        check("midrst b valid", 64'(ifb.r_valid), 64'd0);
        check("midrst b data", ifb.r_data[0 +: DW], 64'd0);
        check("midrst a valid", 64'(ifa.r_valid), 64'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("postrst b valid c%0d", c), 64'(ifb.r_valid), 64'd0);
            check($sformatf("postrst b data c%0d", c), ifb.r_data[0 +: DW], 64'd0);
        end
        check("postrst wcoll", 64'(ifb.wcoll_cnt), 64'd0);
        read_check("postrst", 3'b001, 12'h100, 64'h1122334455667788, 64'h1122334455667788);

        // Saturation: eight colliding bytes per cycle.
        set_write(0, 12'h400, 64'h5555555555555555, 8'hFF);
        set_write(1, 12'h400, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        repeat (8191) tick();
        check("sat below", 64'(ifa.wcoll_cnt), 64'hFFF8);
        tick();
        check("sat reach", 64'(ifa.wcoll_cnt), 64'hFFFF);
        repeat (558) tick();
        clear_inputs();
        check("sat hold a", 64'(ifa.wcoll_cnt), 64'hFFFF);
        check("sat hold b", 64'(ifb.wcoll_cnt), 64'hFFFF);
        read_check("sat data", 3'b010, 12'h400, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
